lmb_bram_dp_ctrl: RTL

LMB_BRAM_DP_CTRL -- requirements
Module: lmb_bram_dp_ctrl

---
 rtl/lmb_bram_pkg.sv | 21 ++
 rtl/lmb_bram_tdp_ram.sv | 37 +++
 rtl/lmb_bram_dp_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lmb_bram_pkg.sv
// lmb_bram_pkg: shared FSM state type and memory geometry helpers for the LMB BRAM controller
package lmb_bram_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lanes_of(input int dwidth);
        return dwidth / 8;
    endfunction

    function automatic int depth_of(input int memsize, input int dwidth);
        return memsize / lanes_of(dwidth);
    endfunction

endpackage

// File: rtl/lmb_bram_tdp_ram.sv
// lmb_bram_tdp_ram: true dual-port byte-write read-first storage array, no reset
// Ports: clk; per port a/b: en access, we byte-lane writes, addr word index,
//        wdata write data, rdata registered read data (old word on writes).
module lmb_bram_tdp_ram #(
    parameter int DEPTH = 4096,
    parameter int NL    = 4,
    parameter int IW    = 12
) (
    input  logic            clk,
    input  logic            en_a,
    input  logic [NL-1:0]   we_a,
    input  logic [IW-1:0]   addr_a,
    input  logic [8*NL-1:0] wdata_a,
    output logic [8*NL-1:0] rdata_a,
    input  logic            en_b,
    input  logic [NL-1:0]   we_b,
    input  logic [IW-1:0]   addr_b,
    input  logic [8*NL-1:0] wdata_b,
    output logic [8*NL-1:0] rdata_b
);

    logic [8*NL-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            rdata_a <= mem[addr_a];
            for (int i = 0; i < NL; i++)
                if (we_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
        end
        if (en_b) begin
            rdata_b <= mem[addr_b];
            for (int i = 0; i < NL; i++)
                if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        end
    end

endmodule

// File: rtl/lmb_bram_dp_ctrl.sv
// lmb_bram_dp_ctrl: dual-port LMB block-RAM controller with power-up zero-fill
// Ports: BRAM_Clk clock, BRAM_Rst_N async active-low reset, Init_Done memory ready;
//        per port x in {A,B}: BRAM_EN_x request, BRAM_WEN_x byte writes (bit 0 = data bits 0:7),
//        BRAM_Addr_x byte address, BRAM_Dout_x write data, BRAM_Din_x read data, Rd_Valid_x read strobe.
module lmb_bram_dp_ctrl
    import lmb_bram_pkg::*;
#(
    parameter int C_MEMSIZE        = 'h4000,
    parameter int C_DWIDTH         = 32,
    parameter int C_AWIDTH         = 32,
    parameter int C_PIPELINE       = 0,
    parameter int C_CLEAR_ON_RESET = 1
) (
    input  logic                  BRAM_Clk,
    input  logic                  BRAM_Rst_N,
    output logic                  Init_Done,
    input  logic                  BRAM_EN_A,
    input  logic [0:C_DWIDTH/8-1] BRAM_WEN_A,
    input  logic [0:C_AWIDTH-1]   BRAM_Addr_A,
    input  logic [0:C_DWIDTH-1]   BRAM_Dout_A,
    output logic [0:C_DWIDTH-1]   BRAM_Din_A,
    output logic                  Rd_Valid_A,
    input  logic                  BRAM_EN_B,
    input  logic [0:C_DWIDTH/8-1] BRAM_WEN_B,
    input  logic [0:C_AWIDTH-1]   BRAM_Addr_B,
    input  logic [0:C_DWIDTH-1]   BRAM_Dout_B,
    output logic [0:C_DWIDTH-1]   BRAM_Din_B,
    output logic                  Rd_Valid_B
);

    localparam int NL    = lanes_of(C_DWIDTH);
    localparam int DEPTH = depth_of(C_MEMSIZE, C_DWIDTH);
    localparam int IW    = clog2(DEPTH);
    localparam int OW    = clog2(NL);

    state_t              state, state_nx;
    logic [IW-1:0]       clr_cnt, idx_a, idx_b, ram_addr_a;
    logic                done, rd_a, rd_b, col, ram_en_a, ram_en_b;
    logic                vld_a, vld_b, vld2_a, vld2_b;
    logic [NL-1:0]       ram_we_a, ram_we_b;
    logic [C_DWIDTH-1:0] ram_wdata_a, q_a, q_b, hold_a, hold_b;

    // Power-of-two depth: truncating the word address is the modulo wrap.
    assign idx_a = IW'(BRAM_Addr_A >> OW);
    assign idx_b = IW'(BRAM_Addr_B >> OW);
    assign rd_a  = done && BRAM_EN_A && !(|BRAM_WEN_A);
    assign rd_b  = done && BRAM_EN_B && !(|BRAM_WEN_B);
    assign col   = done && BRAM_EN_A && BRAM_EN_B && (idx_a == idx_b);

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            state   <= C_CLEAR_ON_RESET != 0 ? CLEAR : READY;
            clr_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            done    <= state_nx == READY;
        end
    end

    // While clearing, port A of the array is taken over by the zero-fill walker.
    always_comb begin
        state_nx    = state;
        ram_en_a    = done && BRAM_EN_A;
        ram_we_a    = done ? BRAM_WEN_A : '0;
        ram_addr_a  = idx_a;
        ram_wdata_a = BRAM_Dout_A;
        if (state == CLEAR) begin
            state_nx    = clr_cnt == IW'(DEPTH - 1) ? READY : CLEAR;
            ram_en_a    = 1'b1;
            ram_we_a    = '1;
            ram_addr_a  = clr_cnt;
            ram_wdata_a = '0;
        end
    end

    // Lanes written by both ports in one cycle are dropped from B so A wins.
    assign ram_en_b = done && BRAM_EN_B;
    assign ram_we_b = ram_en_b ? (BRAM_WEN_B & ~(col ? BRAM_WEN_A : '0)) : '0;

    lmb_bram_tdp_ram #(.DEPTH(DEPTH), .NL(NL), .IW(IW)) u_ram (
        .clk     (BRAM_Clk),
        .en_a    (ram_en_a),
        .we_a    (ram_we_a),
        .addr_a  (ram_addr_a),
        .wdata_a (ram_wdata_a),
        .rdata_a (q_a),
        .en_b    (ram_en_b),
        .we_b    (ram_we_b),
        .addr_b  (idx_b),
        .wdata_b (BRAM_Dout_B),
        .rdata_b (q_b)
    );

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            vld_a  <= 1'b0;
            vld_b  <= 1'b0;
            vld2_a <= 1'b0;
            vld2_b <= 1'b0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            vld_a  <= rd_a;
            vld_b  <= rd_b;
            vld2_a <= vld_a;
            vld2_b <= vld_b;
            hold_a <= vld_a ? q_a : hold_a;
            hold_b <= vld_b ? q_b : hold_b;
        end
    end

    // hold_x doubles as the output stage when pipelined and as the last-value latch otherwise.
    assign Init_Done  = done;
    assign Rd_Valid_A = C_PIPELINE != 0 ? vld2_a : vld_a;
    assign Rd_Valid_B = C_PIPELINE != 0 ? vld2_b : vld_b;
    assign BRAM_Din_A = (C_PIPELINE == 0 && vld_a) ? q_a : hold_a;
    assign BRAM_Din_B = (C_PIPELINE == 0 && vld_b) ? q_b : hold_b;

endmodule
